// File: rtl/neuron_sad_pkg.sv
// Shared types and sizing helpers for the neuron SAD accumulator.
package neuron_sad_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    // Operand width the prefix subtractor is built for
    localparam int unsigned DefaultDataW = 8;

    // Accumulator width that can never overflow for n_pairs operands of data_w bits
    function automatic int unsigned sad_acc_width(input int unsigned n_pairs,
                                                  input int unsigned data_w);
        return data_w + $clog2(n_pairs);
    endfunction

endpackage

// File: rtl/sklansky_subtractor_8bit.sv
// 8-bit Sklansky prefix subtractor: computes a + ~b + 1.
// cout_o is 1 when a >= b (no borrow).
module sklansky_subtractor_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] diff_o,
    output logic       cout_o
);

    logic [7:0] prop;
    logic [7:0] grp_g;
    logic [7:0] grp_p;
    logic [7:0] carry;

    // Bit-level G/P, three Sklansky levels done in place, then sum bits
    always_comb begin
        prop  = a_i ^ ~b_i;
        grp_g = a_i & ~b_i;
        grp_p = prop;
        // Carry-in of 1 folded into the bit-0 generate
        grp_g[0] = grp_g[0] | prop[0];
        for (int lvl = 0; lvl < 3; lvl++) begin
            // Descending order keeps lower-half partners unmodified within a level
            for (int i = 7; i >= 0; i--) begin
                if (((i >> lvl) & 1) != 0) begin
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[((i >> lvl) << lvl) - 1]);
                    grp_p[i] = grp_p[i] & grp_p[((i >> lvl) << lvl) - 1];
                end
            end
        end
        carry  = {grp_g[6:0], 1'b1};
        diff_o = prop ^ carry;
        cout_o = grp_g[7];
    end

endmodule

// File: rtl/neuron_sad_accumulator.sv
// Streaming sum-of-absolute-differences engine, one frame of N_PAIRS pairs per start.
// Optional build macro NEURON_SAD_SATURATE_EN: accumulator saturates instead of wrapping.
module neuron_sad_accumulator
    import neuron_sad_pkg::*;
#(
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned N_PAIRS = 16,
    parameter int unsigned ACC_W   = sad_acc_width(N_PAIRS, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              busy_o,
    output logic [ACC_W-1:0]  sad_o,
    output logic              sad_valid_o
);

    localparam int unsigned CntW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N_PAIRS - 1);

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic [DATA_W-1:0] diff_r_q;
    logic              diff_v_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  sad_q;
    logic              sad_valid_q;

    logic [7:0]        raw_diff;
    logic              raw_cout;
    logic [DATA_W-1:0] abs_diff;
    logic              in_ready;
    logic              accept;

    sklansky_subtractor_8bit u_sub (
        .a_i   (a_i),
        .b_i   (b_i),
        .diff_o(raw_diff),
        .cout_o(raw_cout)
    );

    // Borrow means a < b, so negate the raw difference
    assign abs_diff = raw_cout ? raw_diff : (~raw_diff + 8'd1);

    // Ready is a pure state decode so in_valid never loops back combinationally
    assign in_ready = (state_q == StAccum);
    assign accept   = in_valid_i & in_ready;

`ifdef NEURON_SAD_SATURATE_EN
    logic [ACC_W:0] acc_sum;

    // Saturating accumulate: clamp to all-ones on carry out
    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(diff_r_q);
        acc_d   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
`else
    // Wrapping accumulate
    always_comb begin
        acc_d = acc_q + ACC_W'(diff_r_q);
    end
`endif

    // Frame FSM, diff pipeline register, accumulator and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            diff_r_q    <= '0;
            diff_v_q    <= 1'b0;
            acc_q       <= '0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
        end else begin
            sad_valid_q <= 1'b0;
            diff_v_q    <= 1'b0;
            if (diff_v_q) begin
                acc_q <= acc_d;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q   <= '0;
                        count_q <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        diff_r_q <= abs_diff;
                        diff_v_q <= 1'b1;
                        count_q  <= count_q + 1'b1;
                        if (count_q == LastCnt) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                end
                StDone: begin
                    sad_q       <= acc_q;
                    sad_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = in_ready;
    assign busy_o      = (state_q != StIdle);
    assign sad_o       = sad_q;
    assign sad_valid_o = sad_valid_q;

endmodule

// File: tb/tb_neuron_sad_accumulator.sv
// Directed bench for neuron_sad_accumulator; a 10-bit accumulator copy covers overflow.
module tb_neuron_sad_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;

    logic        in_ready;
    logic        busy;
    logic [11:0] sad;
    logic        sad_valid;

    logic        in_ready10;
    logic        busy10;
    logic [9:0]  sad10;
    logic        sad_valid10;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_sad_accumulator #(
        .DATA_W (8),
        .N_PAIRS(16),
        .ACC_W  (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .busy_o     (busy),
        .sad_o      (sad),
        .sad_valid_o(sad_valid)
    );

    neuron_sad_accumulator #(
        .DATA_W (8),
        .N_PAIRS(16),
        .ACC_W  (10)
    ) dut10 (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready10),
        .busy_o     (busy10),
        .sad_o      (sad10),
        .sad_valid_o(sad_valid10)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int absd(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ready_after_start", in_ready, 1);
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic push(input logic [7:0] pa, input logic [7:0] pb);
        a        = pa;
        b        = pb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called 1ns after the last accept edge k; returns 1ns after edge k+2
    task automatic finish_frame(input int exp, input int exp10, input bit chk10);
        check_eq("drain_ready", in_ready, 0);
        check_eq("drain_busy", busy, 1);
        check_eq("drain_strobe", sad_valid, 0);
        tick();
        check_eq("done_ready", in_ready, 0);
        check_eq("done_strobe", sad_valid, 0);
        tick();
        check_eq("strobe_k2", sad_valid, 1);
        check_eq("sad", sad, exp);
        check_eq("idle_busy", busy, 0);
        if (chk10) begin
            check_eq("sad10", sad10, exp10);
            check_eq("strobe10", sad_valid10, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        int cyc;
        int model;
        int exp10;
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [7:0] ra;
        logic [7:0] rb;

        rst      = 1'b1;
        start    = 1'b1;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;

        // Reset with start held high: start must not take effect
        repeat (3) tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        check_eq("rst_sad", sad, 0);
        check_eq("rst_strobe", sad_valid, 0);
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);

        // 16 x (200,50) back-to-back
        do_start();
        for (int i = 0; i < 16; i++) push(8'd200, 8'd50);
        finish_frame(2400, 0, 1'b0);
        tick();
        check_eq("strobe_drop", sad_valid, 0);
        check_eq("sad_hold", sad, 2400);

        // Alternating pairs with a bubble every third cycle
        do_start();
        accepted = 0;
        cyc      = 0;
        while (accepted < 16) begin
            if (cyc % 3 == 2) begin
                in_valid = 1'b0;
                tick();
                check_eq("bubble_ready", in_ready, 1);
            end else begin
                if (accepted % 2 == 0) push(8'd10, 8'd250);
                else push(8'd250, 8'd10);
                accepted++;
            end
            cyc++;
        end
        finish_frame(3840, 0, 1'b0);
        tick();

        // Max operands: 12-bit exact, 10-bit saturates or wraps
`ifdef NEURON_SAD_SATURATE_EN
        exp10 = 1023;
`else
        exp10 = 1008;
`endif
        do_start();
        for (int i = 0; i < 16; i++) push(8'd255, 8'd0);
        finish_frame(4080, exp10, 1'b1);
        tick();
        check_eq("max_strobe_drop", sad_valid, 0);

        // Partial frame, ignored start, then reset abort
        do_start();
        for (int i = 0; i < 5; i++) push(8'd9, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_ignored_busy", busy, 1);
        check_eq("restart_ignored_ready", in_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_sad", sad, 0);
        check_eq("abort_strobe", sad_valid, 0);
        check_eq("abort_ready", in_ready, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sad10", sad10, 0);
        do_start();
        for (int i = 0; i < 16; i++) push(8'd7, 8'd7);
        finish_frame(0, 0, 1'b1);
        tick();

        // Edge operands against the reference model
        ea = '{8'd0, 8'd255, 8'd128, 8'd127};
        eb = '{8'd255, 8'd255, 8'd127, 8'd128};
        model = 0;
        do_start();
        for (int i = 0; i < 16; i++) begin
            push(ea[i % 4], eb[i % 4]);
            model += absd(int'(ea[i % 4]), int'(eb[i % 4]));
        end
        finish_frame(model, 0, 1'b0);

        // Start in the strobe cycle; previous sad must hold through the new frame
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b2b_strobe_drop", sad_valid, 0);
        check_eq("b2b_ready", in_ready, 1);
        check_eq("b2b_sad_hold", sad, 1028);
        model = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                ra = 8'd3;
                rb = 8'd250;
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
            end
            push(ra, rb);
            model += absd(int'(ra), int'(rb));
        end
        check_eq("rand_sad_hold", sad, 1028);
        finish_frame(model, 0, 1'b0);
        tick();
        check_eq("final_strobe_drop", sad_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_sad_accumulator.md
# neuron_sad_accumulator

Streaming sum-of-absolute-differences (SAD) engine for the neuron datapath. Accepts N_PAIRS unsigned operand pairs over a valid/ready handshake after a start pulse. For each pair it computes |a − b| with an 8-bit Sklansky prefix subtractor, which is the subtract counterpart of the team's prefix adder. It accumulates the differences and presents the frame SAD with a one-cycle sad_valid strobe, so the neuron comparator can consume a single distance per frame.

## Interface
- DATA_W, 8, operand width (prefix subtractor fixed at 8; other values unsupported)
- N_PAIRS, 16, pairs per frame (≥1)
- ACC_W, 12, accumulator/result width; DATA_W+clog2(N_PAIRS) guarantees no overflow

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  frame start pulse; honoured only in IDLE
- a  in  DATA_W  operand A, unsigned
- b  in  DATA_W  operand B, unsigned
- in_valid  in  1  a/b valid
- in_ready  out  1  block accepts a pair this cycle
- busy  out  1  frame in progress (state ≠ IDLE)
- sad  out  ACC_W  frame result; held until next start
- sad_valid  out  1  one-cycle strobe, sad is new

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → acc←0, count←0, state→ACCUM.
- ACCUM:
  - in_ready=1, decoded from state with no combinational path from in_valid.
  - Accept = in_valid & in_ready.
  - Each accept loads diff_r←|a−b| and diff_v←1; otherwise diff_v←0.
  - count increments per accept. The accept with count==N_PAIRS−1 moves state→DRAIN.
- DRAIN: in_ready=0; the final diff is summed; state→DONE.
- DONE: sad←acc, sad_valid←1, state→IDLE.
- Accumulate stage: acc←acc+zero-extend(diff_r) whenever diff_v=1, in any state.
- |a−b| computation:
  - Compute a+~b+1 through the prefix network.
  - Carry-out=1 (a≥b): the raw difference is the result.
  - Carry-out=0: the result is the two's complement of the raw difference.
  - Result is 0..255 exact, e.g. a=3,b=250→247; a=b→0.
- start outside IDLE is ignored; the frame is not restarted.
- start in IDLE in the same cycle sad_valid is high is accepted. sad keeps its value until the new frame's DONE.

## Timing
- Reset values: in_ready=0, busy=0, sad=0, sad_valid=0, acc=0, count=0, diff_v=0, state=IDLE.
- rst has priority over every event. Asserted mid-frame, it aborts the frame and the partial sum is discarded.
- start at edge S → in_ready=1 from the cycle after S.
- Back-to-back: one pair per cycle; a frame of N_PAIRS occupies N_PAIRS cycles of in_ready.
- Last accept at edge k:
  - acc final at edge k+1.
  - sad and sad_valid registered at edge k+2.
  - sad_valid drops at edge k+3.
- Bubbles (in_valid=0) stall count only; there is no timeout.
- Start-to-next-start minimum: N_PAIRS+3 cycles.

## Configuration
- Macro `NEURON_SAD_SATURATE_EN`.
- Defined: accumulator add saturates at 2^ACC_W−1 and stays there for the rest of the frame.
- Undefined: add wraps modulo 2^ACC_W.
- With the default ACC_W the two builds are identical, because overflow is impossible.

## Structure
- Package `neuron_sad_pkg`:
  - state enum (IDLE/ACCUM/DRAIN/DONE)
  - DATA_W default
  - function returning required ACC_W for N_PAIRS
- Sub-module `sklansky_subtractor_8bit`:
  - Combinational prefix subtractor.
  - Outputs an 8-bit difference and carry-out (a≥b).
  - Reuses generate/propagate and black/gray cell structure, with carry-in forced to 1.
- Top contains the FSM, counter, diff register, accumulator and output register.

## Test plan
- Reset, then idle 5 cycles → sad=0, sad_valid=0, in_ready=0, busy=0; start during rst ignored.
- start; 16 back-to-back pairs a=200,b=50 → sad=2400 (0x960), sad_valid high exactly 2 cycles after last accept edge, for 1 cycle.
- 16 pairs alternating (10,250)/(250,10) with in_valid bubbles every third cycle → sad=3840; in_ready low in DRAIN/DONE.
- 16 pairs a=255,b=0 → sad=4080. With ACC_W=10:
  - macro defined → 1023
  - macro undefined → 1008
- start, 5 accepts, start pulse (ignored), rst → all outputs 0. New frame of 16×(7,7) → sad=0 with sad_valid strobe.
- Edge operands across frames (0,255),(255,255),(128,127),(127,128) → per-pair diffs 255,0,1,1, checked against the accumulated SAD of a reference model.
